ltssm_link_ctrl: RTL and testbench

Parametrised successor to the main LTSSM/LPIF controller. It tracks one joint Tx/Rx LTSSM substate from Detect through Configuration to L0, and adds Recovery (retrain) handling, per-substate timeouts, lane-count scaling and optional speed change. It sits between the per-direction Tx/Rx LTSSM engines (finish/goto handshakes) and the LPIF adapter (state request/status).

---
 rtl/ltssm_link_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ltssm_link_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltssm_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ltssm_link_ctrl
// Desc     : Joint Tx/Rx LTSSM substate controller between the per-direction
//            LTSSM engines (finish/goto handshakes) and the LPIF adapter
//            (state request/status). Covers Detect, Polling, Configuration,
//            L0 and Recovery, with per-substate timeout, lane-count clamping
//            and a saturating retrain counter.
// Options  : `define SPEED_CHANGE_EN adds the recSpeed substate and lets
//            Recovery raise GEN to the highest advertised rate <= MAXGEN.
//            Without it recSpeed is unreachable and GEN stays at 1.
// Revision : 1.0 - initial release
// ============================================================================
module ltssm_link_ctrl #(
    parameter int  DEVICETYPE     = 0,
    parameter int  MAXLANES       = 16,
    parameter int  MAXGEN         = 5,
    parameter int  TIMEOUT_CYCLES = 1000,
    parameter int  TIMER_W        = 20,
    localparam int LW             = $clog2(MAXLANES) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    lpifStateRequest,
    input  logic          finishTx,
    input  logic          finishRx,
    input  logic [3:0]    gotoTx,
    input  logic [3:0]    gotoRx,
    input  logic          forceDetect,
    input  logic [LW-1:0] numberOfDetectedLanesIn,
    input  logic          writeNumberOfDetectedLanes,
    input  logic [7:0]    rateIdIn,
    input  logic          writeRateId,
    output logic          linkUp,
    output logic [2:0]    GEN,
    output logic [3:0]    lpifStateStatus,
    output logic [3:0]    substateTx,
    output logic [3:0]    substateRx,
    output logic [LW-1:0] numberOfDetectedLanesOut,
    output logic          timeoutEvent,
    output logic [7:0]    recoveryCount
);

    // Substate encodings
    localparam logic [3:0] c_DETECT_QUIET    = 4'd0;
    localparam logic [3:0] c_DETECT_ACTIVE   = 4'd1;
    localparam logic [3:0] c_POLL_ACTIVE     = 4'd2;
    localparam logic [3:0] c_POLL_CONFIG     = 4'd3;
    localparam logic [3:0] c_CFG_LW_START    = 4'd4;
    localparam logic [3:0] c_CFG_LW_ACCEPT   = 4'd5;
    localparam logic [3:0] c_CFG_LN_WAIT     = 4'd6;
    localparam logic [3:0] c_CFG_LN_ACCEPT   = 4'd7;
    localparam logic [3:0] c_CFG_COMPLETE    = 4'd8;
    localparam logic [3:0] c_CFG_IDLE        = 4'd9;
    localparam logic [3:0] c_L0              = 4'd10;
    localparam logic [3:0] c_REC_RCVR_LOCK   = 4'd11;
    localparam logic [3:0] c_REC_RCVR_CFG    = 4'd12;
    localparam logic [3:0] c_REC_IDLE        = 4'd13;
    localparam logic [3:0] c_REC_SPEED       = 4'd14;

    // LPIF request / status encodings
    localparam logic [3:0] c_LPIF_RESET      = 4'd0;
    localparam logic [3:0] c_LPIF_ACTIVE     = 4'd1;
    localparam logic [3:0] c_LPIF_RETRAIN    = 4'd2;

    localparam logic [2:0] c_GEN1            = 3'd1;
    localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0]      c_MAX_LANES  = LW'(MAXLANES);

    logic [3:0]         r_substate;
    logic [3:0]         w_nextSubstate;
    logic [3:0]         r_status;
    logic [3:0]         w_nextStatus;
    logic               r_linkUp;
    logic               w_nextLinkUp;
    logic [2:0]         r_gen;
    logic [2:0]         w_nextGen;
    logic               r_timeoutEvent;
    logic               w_nextTimeoutEvent;
    logic [7:0]         r_recoveryCount;
    logic [7:0]         w_nextRecoveryCount;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_nextTimer;
    logic [LW-1:0]      r_lanes;
    logic [LW-1:0]      w_lanesClamped;
    logic [7:0]         r_rateId;

    logic [3:0]         w_seqNext;
    logic               w_txSeq;
    logic               w_rxSeq;
    logic               w_bothSeq;
    logic               w_bothGotoL0;
    logic               w_fallbackHit;
    logic               w_timeoutHit;

    // Handshake decode: "Seq" means the engine asks for the next linear substate
    assign w_seqNext     = r_substate + 4'd1;
    assign w_txSeq       = finishTx && (gotoTx == w_seqNext);
    assign w_rxSeq       = finishRx && (gotoRx == w_seqNext);
    assign w_bothSeq     = w_txSeq && w_rxSeq;
    assign w_bothGotoL0  = finishTx && finishRx && (gotoTx == c_L0) && (gotoRx == c_L0);

    // Either engine may bail out to detectQuiet anywhere except L0
    assign w_fallbackHit = (r_substate != c_L0) &&
                           ((finishTx && (gotoTx == c_DETECT_QUIET)) ||
                            (finishRx && (gotoRx == c_DETECT_QUIET)));
    assign w_timeoutHit  = (r_substate != c_L0) && (r_timer == c_TIMER_LAST);

`ifdef SPEED_CHANGE_EN
    logic [2:0] w_targetGen;
    logic       w_speedUp;
    logic       w_bothGotoRcvrLock;

    assign w_bothGotoRcvrLock = finishTx && finishRx &&
                                (gotoTx == c_REC_RCVR_LOCK) && (gotoRx == c_REC_RCVR_LOCK);
    assign w_speedUp          = (w_targetGen > r_gen);

    // Highest advertised generation that this instance supports (Gen1 if none)
    always_comb begin
        w_targetGen = c_GEN1;
        for (int k = 0; k < 8; k++) begin
            if (r_rateId[k] && ((k + 1) <= MAXGEN)) begin
                w_targetGen = 3'(k + 1);
            end
        end
    end
`else
    logic w_unusedSpeed;
    assign w_unusedSpeed = ^{r_rateId, 3'(MAXGEN)};
`endif

    // State register: substate, timer and all registered LPIF-facing outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_substate      <= c_DETECT_QUIET;
            r_status        <= c_LPIF_RESET;
            r_linkUp        <= 1'b0;
            r_gen           <= c_GEN1;
            r_timeoutEvent  <= 1'b0;
            r_recoveryCount <= 8'd0;
            r_timer         <= '0;
        end else begin
            r_substate      <= w_nextSubstate;
            r_status        <= w_nextStatus;
            r_linkUp        <= w_nextLinkUp;
            r_gen           <= w_nextGen;
            r_timeoutEvent  <= w_nextTimeoutEvent;
            r_recoveryCount <= w_nextRecoveryCount;
            r_timer         <= w_nextTimer;
        end
    end

    // Next-state: forceDetect > fallback > timeout > advance; timer follows substate
    always_comb begin
        w_nextSubstate = r_substate;
        if (forceDetect || w_fallbackHit || w_timeoutHit) begin
            w_nextSubstate = c_DETECT_QUIET;
        end else begin
            case (r_substate)
                c_DETECT_QUIET, c_DETECT_ACTIVE, c_POLL_ACTIVE, c_POLL_CONFIG,
                c_CFG_COMPLETE, c_REC_RCVR_LOCK: begin
                    if (w_bothSeq) w_nextSubstate = w_seqNext;
                end
                // Lane-number negotiation is driven by the receiver alone
                c_CFG_LW_START, c_CFG_LN_WAIT, c_CFG_LN_ACCEPT: begin
                    if (w_rxSeq) w_nextSubstate = w_seqNext;
                end
                // A downstream port proceeds as soon as its transmitter is done
                c_CFG_LW_ACCEPT: begin
                    if ((DEVICETYPE == 0) ? w_txSeq : w_bothSeq) w_nextSubstate = w_seqNext;
                end
                // linkUp is raised here first; L0 is entered only once LPIF asks
                c_CFG_IDLE: begin
                    if (r_linkUp && (lpifStateRequest == c_LPIF_ACTIVE)) w_nextSubstate = c_L0;
                end
                c_L0: begin
                    if (lpifStateRequest == c_LPIF_RESET) begin
                        w_nextSubstate = c_DETECT_QUIET;
                    end else if (lpifStateRequest == c_LPIF_RETRAIN) begin
                        w_nextSubstate = c_REC_RCVR_LOCK;
                    end
                end
                c_REC_RCVR_CFG: begin
                    if (w_bothSeq) begin
`ifdef SPEED_CHANGE_EN
                        w_nextSubstate = w_speedUp ? c_REC_SPEED : c_REC_IDLE;
`else
                        w_nextSubstate = c_REC_IDLE;
`endif
                    end
                end
                c_REC_IDLE: begin
                    if (w_bothGotoL0) w_nextSubstate = c_L0;
                end
`ifdef SPEED_CHANGE_EN
                c_REC_SPEED: begin
                    if (w_bothGotoRcvrLock) w_nextSubstate = c_REC_RCVR_LOCK;
                end
`endif
                default: w_nextSubstate = c_DETECT_QUIET;
            endcase
        end

        // The timer is frozen in L0 and restarts whenever the substate is re-entered
        if (forceDetect || w_fallbackHit || w_timeoutHit ||
            (w_nextSubstate != r_substate) || (r_substate == c_L0)) begin
            w_nextTimer = '0;
        end else begin
            w_nextTimer = r_timer + 1'b1;
        end
    end

    // Output logic: LPIF status, linkUp, GEN, retrain count and timeout pulse
    always_comb begin
        w_nextStatus        = r_status;
        w_nextLinkUp        = r_linkUp;
        w_nextGen           = r_gen;
        w_nextRecoveryCount = r_recoveryCount;
        w_nextTimeoutEvent  = 1'b0;
        if (forceDetect) begin
            w_nextStatus = c_LPIF_RESET;
            w_nextLinkUp = 1'b0;
            w_nextGen    = c_GEN1;
        end else if (w_fallbackHit || w_timeoutHit) begin
            w_nextStatus       = c_LPIF_RESET;
            w_nextLinkUp       = 1'b0;
            w_nextTimeoutEvent = w_timeoutHit && !w_fallbackHit;
        end else begin
            case (r_substate)
                c_CFG_IDLE: begin
                    if (w_bothGotoL0) w_nextLinkUp = 1'b1;
                    if (w_nextSubstate == c_L0) w_nextStatus = c_LPIF_ACTIVE;
                end
                c_L0: begin
                    if (w_nextSubstate == c_DETECT_QUIET) begin
                        w_nextStatus = c_LPIF_RESET;
                        w_nextLinkUp = 1'b0;
                    end else if (w_nextSubstate == c_REC_RCVR_LOCK) begin
                        w_nextStatus = c_LPIF_RETRAIN;
                    end
                end
                c_REC_IDLE: begin
                    if (w_nextSubstate == c_L0) begin
                        w_nextStatus = c_LPIF_ACTIVE;
                        if (r_recoveryCount != 8'hFF) w_nextRecoveryCount = r_recoveryCount + 8'd1;
                    end
                end
`ifdef SPEED_CHANGE_EN
                c_REC_SPEED: begin
                    if (w_nextSubstate == c_REC_RCVR_LOCK) w_nextGen = w_targetGen;
                end
`endif
                default: ;
            endcase
        end
    end

    // Lane count and advertised-rate registers load in any substate
    assign w_lanesClamped = (numberOfDetectedLanesIn > c_MAX_LANES) ? c_MAX_LANES
                                                                    : numberOfDetectedLanesIn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lanes  <= '0;
            r_rateId <= 8'd0;
        end else begin
            if (writeNumberOfDetectedLanes) r_lanes <= w_lanesClamped;
            if (writeRateId) r_rateId <= rateIdIn;
        end
    end

    assign linkUp                   = r_linkUp;
    assign GEN                      = r_gen;
    assign lpifStateStatus          = r_status;
    assign substateTx               = r_substate;
    assign substateRx               = r_substate;
    assign numberOfDetectedLanesOut = r_lanes;
    assign timeoutEvent             = r_timeoutEvent;
    assign recoveryCount            = r_recoveryCount;

endmodule
`default_nettype wire

// File: tb/tb_ltssm_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltssm_link_ctrl
// Desc     : Self-checking bench for ltssm_link_ctrl. Two instances share all
//            inputs: u_dut0 is a downstream port, u_dut1 an upstream port.
//            Build with or without SPEED_CHANGE_EN to match the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltssm_link_ctrl;

    localparam int LW = 5;

    typedef struct packed {
        logic [3:0] sub;
        logic [3:0] stat;
        logic       link;
        logic [2:0] gen;
        logic       tevt;
        logic [7:0] rec;
        logic [4:0] lanes;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       fTx;
        logic [3:0] gTx;
        logic       fRx;
        logic [3:0] gRx;
        logic       frc;
        logic       wrL;
        logic [4:0] lanesIn;
        logic       wrR;
        logic [7:0] rate;
        exp_t       e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    lpifStateRequest;
    logic          finishTx;
    logic          finishRx;
    logic [3:0]    gotoTx;
    logic [3:0]    gotoRx;
    logic          forceDetect;
    logic [LW-1:0] lanesIn;
    logic          wrLanes;
    logic [7:0]    rateIdIn;
    logic          writeRateId;

    logic          linkUp0;
    logic [2:0]    gen0;
    logic [3:0]    status0;
    logic [3:0]    subTx0;
    logic [3:0]    subRx0;
    logic [LW-1:0] lanes0;
    logic          tevt0;
    logic [7:0]    rec0;

    logic [3:0]    subTx1;
    logic          d1_unusedLink;
    logic [2:0]    d1_unusedGen;
    logic [3:0]    d1_unusedStatus;
    logic [3:0]    d1_unusedSubRx;
    logic [LW-1:0] d1_unusedLanes;
    logic          d1_unusedTevt;
    logic [7:0]    d1_unusedRec;

    int   errors = 0;
    int   checks = 0;
    int   eRec;
    exp_t sbq[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ltssm_link_ctrl #(
        .DEVICETYPE(0), .MAXLANES(16), .MAXGEN(3), .TIMEOUT_CYCLES(8), .TIMER_W(20)
    ) u_dut0 (
        .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest),
        .finishTx(finishTx), .finishRx(finishRx), .gotoTx(gotoTx), .gotoRx(gotoRx),
        .forceDetect(forceDetect), .numberOfDetectedLanesIn(lanesIn),
        .writeNumberOfDetectedLanes(wrLanes), .rateIdIn(rateIdIn), .writeRateId(writeRateId),
        .linkUp(linkUp0), .GEN(gen0), .lpifStateStatus(status0),
        .substateTx(subTx0), .substateRx(subRx0), .numberOfDetectedLanesOut(lanes0),
        .timeoutEvent(tevt0), .recoveryCount(rec0)
    );

    ltssm_link_ctrl #(
        .DEVICETYPE(1), .MAXLANES(16), .MAXGEN(3), .TIMEOUT_CYCLES(8), .TIMER_W(20)
    ) u_dut1 (
        .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest),
        .finishTx(finishTx), .finishRx(finishRx), .gotoTx(gotoTx), .gotoRx(gotoRx),
        .forceDetect(forceDetect), .numberOfDetectedLanesIn(lanesIn),
        .writeNumberOfDetectedLanes(wrLanes), .rateIdIn(rateIdIn), .writeRateId(writeRateId),
        .linkUp(d1_unusedLink), .GEN(d1_unusedGen), .lpifStateStatus(d1_unusedStatus),
        .substateTx(subTx1), .substateRx(d1_unusedSubRx), .numberOfDetectedLanesOut(d1_unusedLanes),
        .timeoutEvent(d1_unusedTevt), .recoveryCount(d1_unusedRec)
    );

    // Build one vector: inputs, then the expected u_dut0 outputs after the next edge
    function automatic vec_t mkv(input logic [3:0] req, input logic fTx, input logic [3:0] gTx,
                                 input logic fRx, input logic [3:0] gRx,
                                 input logic [3:0] sub, input logic [3:0] stat, input logic link,
                                 input logic [2:0] gen, input logic [7:0] rec, input logic [4:0] lanes);
        vec_t v;
        v.req = req; v.fTx = fTx; v.gTx = gTx; v.fRx = fRx; v.gRx = gRx;
        v.frc = 1'b0; v.wrL = 1'b0; v.lanesIn = 5'd0; v.wrR = 1'b0; v.rate = 8'd0;
        v.e.sub = sub; v.e.stat = stat; v.e.link = link; v.e.gen = gen;
        v.e.tevt = 1'b0; v.e.rec = rec; v.e.lanes = lanes;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        lpifStateRequest = v.req;
        finishTx         = v.fTx;
        gotoTx           = v.gTx;
        finishRx         = v.fRx;
        gotoRx           = v.gRx;
        forceDetect      = v.frc;
        wrLanes          = v.wrL;
        lanesIn          = v.lanesIn;
        writeRateId      = v.wrR;
        rateIdIn         = v.rate;
    endtask

    task automatic compareExp(input string name, input exp_t e);
        exp_t a;
        a.sub = subTx0; a.stat = status0; a.link = linkUp0; a.gen = gen0;
        a.tevt = tevt0; a.rec = rec0; a.lanes = lanes0;
        checks++;
        if (a !== e || subRx0 !== e.sub) begin
            errors++;
            $display("FAIL %s: actual sub=%0d/%0d stat=%0d link=%0b gen=%0d tevt=%0b rec=%0d lanes=%0d required sub=%0d stat=%0d link=%0b gen=%0d tevt=%0b rec=%0d lanes=%0d",
                     name, a.sub, subRx0, a.stat, a.link, a.gen, a.tevt, a.rec, a.lanes,
                     e.sub, e.stat, e.link, e.gen, e.tevt, e.rec, e.lanes);
        end
    endtask

    task automatic check1(input string name, input logic [3:0] expSub);
        checks++;
        if (subTx1 !== expSub) begin
            errors++;
            $display("FAIL %s: upstream substate actual=%0d required=%0d", name, subTx1, expSub);
        end
    endtask

    // Drive a vector, queue its expectation, compare one edge later
    task automatic step(input string name, input vec_t v);
        drive(v);
        sbq.push_back(v.e);
        @(posedge clk);
        #1;
        compareExp(name, sbq.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        exp_t rstExp;

        // ---- training table: Detect through Configuration into L0 ----
        tbl.push_back(mkv(0, 1, 1,  1, 1,  1,  0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, 5,  1, 5,  1,  0, 0, 1, 0, 0));   // non-matching goto holds
        tbl.push_back(mkv(0, 1, 2,  1, 2,  2,  0, 0, 1, 0, 0));
        v = mkv(0, 1, 3,  1, 3,  3,  0, 0, 1, 0, 16); v.wrL = 1'b1; v.lanesIn = 5'd20;
        tbl.push_back(v);                                          // clamp to MAXLANES
        tbl.push_back(mkv(0, 0, 0,  1, 4,  3,  0, 0, 1, 0, 16));  // Rx alone is not enough here
        v = mkv(0, 1, 4,  1, 4,  4,  0, 0, 1, 0, 9);  v.wrL = 1'b1; v.lanesIn = 5'd9;
        tbl.push_back(v);
        tbl.push_back(mkv(0, 0, 0,  1, 5,  5,  0, 0, 1, 0, 9));   // Rx alone at 4
        tbl.push_back(mkv(0, 1, 6,  1, 6,  6,  0, 0, 1, 0, 9));
        tbl.push_back(mkv(0, 0, 0,  1, 7,  7,  0, 0, 1, 0, 9));
        tbl.push_back(mkv(0, 0, 0,  1, 8,  8,  0, 0, 1, 0, 9));
        tbl.push_back(mkv(0, 1, 9,  1, 9,  9,  0, 0, 1, 0, 9));
        tbl.push_back(mkv(0, 1, 10, 1, 10, 9,  0, 1, 1, 0, 9));   // linkUp, still cfgIdle
        tbl.push_back(mkv(1, 0, 0,  0, 0,  10, 1, 1, 1, 0, 9));   // LPIF active -> L0

        // ---- reset state ----
        reset = 1'b0;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rstExp = '{sub: 4'd0, stat: 4'd0, link: 1'b0, gen: 3'd1, tevt: 1'b0, rec: 8'd0, lanes: 5'd0};
        compareExp("reset_state", rstExp);
        check1("reset_state_up", 4'd0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("train%0d", i), tbl[i]);
        end

        // L0 never times out
        for (int i = 0; i < 10; i++) begin
            step("l0_hold", mkv(1, 0, 0, 0, 0, 10, 1, 1, 1, 0, 9));
            if (i == 0) check1("up_l0", 4'd10);
        end

        // ---- 256 retrains, counter saturates at 255 ----
        eRec = 0;
        for (int n = 1; n <= 256; n++) begin
            step("rt_req", mkv(2, 0, 0,  0, 0,  11, 2, 1, 1, 8'(eRec), 9));
            step("rt_12",  mkv(1, 1, 12, 1, 12, 12, 2, 1, 1, 8'(eRec), 9));
            step("rt_13",  mkv(1, 1, 13, 1, 13, 13, 2, 1, 1, 8'(eRec), 9));
            if (eRec != 255) eRec++;
            step("rt_l0",  mkv(1, 1, 10, 1, 10, 10, 1, 1, 1, 8'(eRec), 9));
        end

        // ---- speed change: rates Gen1..Gen4 advertised, MAXGEN=3 ----
        v = mkv(1, 0, 0, 0, 0, 10, 1, 1, 1, 255, 9); v.wrR = 1'b1; v.rate = 8'h0F;
        step("rate_wr", v);
        step("sp_req", mkv(2, 0, 0,  0, 0,  11, 2, 1, 1, 255, 9));
        step("sp_12",  mkv(1, 1, 12, 1, 12, 12, 2, 1, 1, 255, 9));
`ifdef SPEED_CHANGE_EN
        step("sp_14",  mkv(1, 1, 13, 1, 13, 14, 2, 1, 1, 255, 9));
        step("sp_gen", mkv(1, 1, 11, 1, 11, 11, 2, 1, 3, 255, 9));
        step("sp_12b", mkv(1, 1, 12, 1, 12, 12, 2, 1, 3, 255, 9));
        step("sp_13b", mkv(1, 1, 13, 1, 13, 13, 2, 1, 3, 255, 9));
        step("sp_l0",  mkv(1, 1, 10, 1, 10, 10, 1, 1, 3, 255, 9));
`else
        step("sp_13",  mkv(1, 1, 13, 1, 13, 13, 2, 1, 1, 255, 9));
        step("sp_l0",  mkv(1, 1, 10, 1, 10, 10, 1, 1, 1, 255, 9));
`endif

        // ---- asynchronous reset in the middle of L0 ----
        drive(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        #3;
        reset = 1'b0;
        #1;
        compareExp("async_reset", rstExp);
        check1("async_reset_up", 4'd0);
        @(posedge clk);
        #1;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        reset = 1'b1;

        // ---- DEVICETYPE rule at cfgLinkWidthAccept ----
        for (int n = 1; n <= 5; n++) begin
            step("retrain_to5", mkv(0, 1, 4'(n), 1, 4'(n), 4'(n), 0, 0, 1, 0, 0));
        end
        step("dt0_tx_only", mkv(0, 1, 6, 0, 0, 6, 0, 0, 1, 0, 0));
        check1("dt1_holds", 4'd5);
        step("rx_only_6",   mkv(0, 0, 0, 1, 7, 7, 0, 0, 1, 0, 0));

        // ---- forceDetect beats a valid advance at state 7 ----
        v = mkv(0, 0, 0, 1, 8, 0, 0, 0, 1, 0, 0); v.frc = 1'b1;
        step("force_at7", v);
        check1("force_up", 4'd0);

        // ---- fallback has priority over advance ----
        step("fb_1",   mkv(0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0));
        step("fb_2",   mkv(0, 1, 2, 1, 2, 2, 0, 0, 1, 0, 0));
        step("fb_pri", mkv(0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0));

        // ---- timeout: 8 cycles after entering pollingConfiguration ----
        step("to_1", mkv(0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0));
        step("to_2", mkv(0, 1, 2, 1, 2, 2, 0, 0, 1, 0, 0));
        step("to_3", mkv(0, 1, 3, 1, 3, 3, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 7; k++) begin
            step($sformatf("to_hold%0d", k), mkv(0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0));
        end
        v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); v.e.tevt = 1'b1;
        step("to_fire", v);
        step("to_pulse_end", mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
